// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl: cache-miss fill engine for the main memory's block port.
// Accepts one miss at a time, optionally writes the dirty victim back,
// reads the missed block, then hands it to the cache over valid/ready.
// Every memory access holds address/enable/data stable for MEM_LAT cycles.
module mem_fill_ctrl #(
    parameter int MEM_LAT   = 4,
    parameter int CNT_W     = 16,
    parameter int PA_WIDTH  = 10,
    parameter int BLK_WIDTH = 128,
    parameter int BYTE      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_dirty,
    input  logic [PA_WIDTH-1:0]  req_victim_addr,
    input  logic [BLK_WIDTH-1:0] req_victim_data,
    input  logic [PA_WIDTH-1:0]  req_fill_addr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [BLK_WIDTH-1:0] resp_data,
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BLK_WIDTH-1:0] mem_wr_data,
    input  logic [BLK_WIDTH-1:0] mem_rd_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     wb_count,
    output logic [CNT_W-1:0]     fill_count
);

    localparam int BLK_BYTES = BLK_WIDTH / BYTE;
    localparam int OFS       = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 0;
    localparam int LAT_W     = $clog2(MEM_LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Clears the byte-offset bits so only block-aligned addresses reach memory.
    localparam logic [PA_WIDTH-1:0] ALIGN_MASK = {PA_WIDTH{1'b1}} << OFS;
    localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(1);

    logic [1:0]           state_reg, state_next;
    logic [LAT_W-1:0]     lat_reg, lat_next;
    logic [PA_WIDTH-1:0]  victim_addr_reg;
    logic [PA_WIDTH-1:0]  fill_addr_reg;
    logic [BLK_WIDTH-1:0] victim_data_reg;
    logic [BLK_WIDTH-1:0] resp_data_reg;
    logic                 accept;
    logic                 wb_done;
    logic                 fill_done;
    logic [1:0]           cnt_inc;
    logic [CNT_W-1:0]     cnt_reg [2];

    // Next-state and latency-counter logic; the counter is reloaded on entry
    // to WB and FILL and the access ends on the cycle it reads 1.
    always_comb begin
        state_next = state_reg;
        lat_next   = lat_reg;
        accept     = 1'b0;
        wb_done    = 1'b0;
        fill_done  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = req_dirty ? S_WB : S_FILL;
                    lat_next   = LAT_LOAD;
                end
            end
            S_WB: begin
                if (lat_reg == LAT_LAST) begin
                    wb_done    = 1'b1;
                    state_next = S_FILL;
                    lat_next   = LAT_LOAD;
                end else begin
                    lat_next = lat_reg - LAT_LAST;
                end
            end
            S_FILL: begin
                if (lat_reg == LAT_LAST) begin
                    fill_done  = 1'b1;
                    state_next = S_RESP;
                    lat_next   = '0;
                end else begin
                    lat_next = lat_reg - LAT_LAST;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                lat_next   = '0;
            end
        endcase
    end

    // State, latency counter, latched request and captured fill data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            lat_reg         <= '0;
            victim_addr_reg <= '0;
            fill_addr_reg   <= '0;
            victim_data_reg <= '0;
            resp_data_reg   <= '0;
        end else begin
            state_reg <= state_next;
            lat_reg   <= lat_next;
            if (accept) begin
                victim_addr_reg <= req_victim_addr & ALIGN_MASK;
                fill_addr_reg   <= req_fill_addr & ALIGN_MASK;
                victim_data_reg <= req_victim_data;
            end
            if (fill_done) begin
                resp_data_reg <= mem_rd_data;
            end
        end
    end

    assign cnt_inc = {fill_done, wb_done};

    // Saturating completion counters: index 0 counts writebacks, 1 counts fills.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    // Outputs decode straight from the state register, so the WB->FILL
    // switch moves address and both enables on the same edge.
    assign req_ready   = (state_reg == S_IDLE);
    assign busy        = (state_reg != S_IDLE);
    assign resp_valid  = (state_reg == S_RESP);
    assign resp_data   = resp_data_reg;
    assign mem_wr_en   = (state_reg == S_WB);
    assign mem_rd_en   = (state_reg == S_FILL);
    assign mem_wr_data = (state_reg == S_WB) ? victim_data_reg : '0;
    assign mem_addr    = (state_reg == S_WB)   ? victim_addr_reg :
                         (state_reg == S_FILL) ? fill_addr_reg   : '0;
    assign wb_count    = cnt_reg[0];
    assign fill_count  = cnt_reg[1];

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// tb_mem_fill_ctrl: byte-array memory model plus scoreboard of expected
// fill data; per-cycle checks of the memory port during each miss.
module tb_mem_fill_ctrl;

    localparam int PA_W  = 10;
    localparam int BLK_W = 128;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_dirty;
    logic [PA_W-1:0]  req_victim_addr;
    logic [BLK_W-1:0] req_victim_data;
    logic [PA_W-1:0]  req_fill_addr;
    logic             resp_valid;
    logic             resp_ready;
    logic [BLK_W-1:0] resp_data;
    logic [PA_W-1:0]  mem_addr;
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic [BLK_W-1:0] mem_wr_data;
    logic [BLK_W-1:0] mem_rd_data;
    logic             busy;
    logic [15:0]      wb_count;
    logic [15:0]      fill_count;

    logic [7:0]       mem [0:1023];
    logic             load_mem;
    logic [BLK_W-1:0] exp_q [$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               exp_wb   = 0;
    int               exp_fill = 0;

    mem_fill_ctrl #(
        .MEM_LAT(4), .CNT_W(16), .PA_WIDTH(PA_W), .BLK_WIDTH(BLK_W), .BYTE(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_dirty(req_dirty),
        .req_victim_addr(req_victim_addr), .req_victim_data(req_victim_data),
        .req_fill_addr(req_fill_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .busy(busy), .wb_count(wb_count), .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    // Memory model: byte i of a block sits at bits [8i+7:8i]; writes land on
    // the clock edge, reads are combinational.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 1024; i++) begin
                if (i >= 'h40 && i < 'h50) mem[i] <= 8'(i - 'h40);
                else                       mem[i] <= 8'(i) ^ 8'h5A;
            end
        end else if (mem_wr_en) begin
            for (int i = 0; i < 16; i++) mem[int'(mem_addr) + i] <= mem_wr_data[8*i +: 8];
        end
    end

    always_comb begin
        mem_rd_data = '0;
        for (int i = 0; i < 16; i++) mem_rd_data[8*i +: 8] = mem[int'(mem_addr) + i];
    end

    task automatic check(input string tag, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one miss and checks the memory port cycle by cycle, then the
    // response. hold = extra cycles of resp_ready=0 after resp_valid rises.
    task automatic run_miss(input logic [PA_W-1:0] v, input logic [BLK_W-1:0] vd, input logic d,
                            input logic [PA_W-1:0] f, input int hold, input logic keep_valid);
        logic [PA_W-1:0]  va, fa, ea;
        logic [BLK_W-1:0] exp_data, ewd;
        int wb, last;
        va = v & 10'h3F0;
        fa = f & 10'h3F0;
        exp_data = '0;
        if (d && va == fa) exp_data = vd;
        else for (int i = 0; i < 16; i++) exp_data[8*i +: 8] = mem[int'(fa) + i];
        wb   = d ? 4 : 0;
        last = wb + 5;
        @(negedge clk);
        check("idle_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_dirty = d; req_victim_addr = v;
        req_victim_data = vd; req_fill_addr = f;
        resp_ready = (hold == 0);
        exp_q.push_back(exp_data);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            ea  = (c <= wb) ? va : (c <= wb + 4) ? fa : '0;
            ewd = (c <= wb) ? vd : '0;
            check("wr_en", mem_wr_en, c <= wb);
            check("rd_en", mem_rd_en, c > wb && c <= wb + 4);
            check("mem_addr", mem_addr, ea);
            check("wr_data", mem_wr_data, ewd);
            check("resp_valid", resp_valid, c == last);
            check("busy_ready", {busy, req_ready}, 2'b10);
            if (!keep_valid) req_valid = 1'b0;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1'b1);
            check("hold_data", resp_data, exp_data);
            check("hold_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        if (exp_q.size() == 0) check("sb_empty", 1'b1, 1'b0);
        else check("resp_data", resp_data, exp_q.pop_front());
        $display("txn: victim=%h dirty=%0d fill=%h data=%h", v, d, f, resp_data);
        if (d) exp_wb++;
        exp_fill++;
        @(negedge clk);
        check("post_valid", resp_valid, 1'b0);
        check("post_idle", {busy, req_ready}, 2'b01);
        check("wb_count", wb_count, 128'(exp_wb));
        check("fill_count", fill_count, 128'(exp_fill));
        req_valid = 1'b0;
    endtask

    initial begin
        logic [BLK_W-1:0] blk;
        rst_n = 1'b0; load_mem = 1'b1;
        req_valid = 1'b0; req_dirty = 1'b0; req_victim_addr = '0;
        req_victim_data = '0; req_fill_addr = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_outs", {busy, resp_valid, mem_rd_en, mem_wr_en}, 4'b0000);
        check("rst_addr", mem_addr, '0);
        check("rst_cnt", {wb_count, fill_count}, '0);
        load_mem = 1'b0; rst_n = 1'b1;

        // Clean miss, then explicit byte-order check of the held response.
        run_miss(10'h000, '0, 1'b0, 10'h040, 0, 1'b0);
        check("clean_bytes", resp_data, 128'h0F0E0D0C0B0A09080706050403020100);

        // Dirty miss and the written-back block contents.
        run_miss(10'h080, {16{8'hAA}}, 1'b1, 10'h040, 0, 1'b0);
        for (int i = 0; i < 16; i++) blk[8*i +: 8] = mem['h80 + i];
        check("wb_mem", blk, {16{8'hAA}});

        // Backpressure: resp_ready low for 6 RESP cycles with req_valid held.
        run_miss(10'h000, '0, 1'b0, 10'h080, 5, 1'b1);

        // Unaligned addresses falling in the same block.
        run_miss(10'h04C, {16{8'h55}}, 1'b1, 10'h047, 0, 1'b0);

        // Reset in the middle of a writeback.
        @(negedge clk);
        req_valid = 1'b1; req_dirty = 1'b1; req_victim_addr = 10'h100;
        req_victim_data = {4{32'hDEADBEEF}}; req_fill_addr = 10'h0C0;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_wb_en", mem_wr_en, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_en_drop", {mem_wr_en, mem_rd_en}, 2'b00);
        check("rst_idle", {busy, req_ready}, 2'b01);
        check("rst_counts", {wb_count, fill_count}, '0);
        exp_wb = 0; exp_fill = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_resp", {resp_valid, busy}, 2'b00);
        end
        run_miss(10'h100, {4{32'h01234567}}, 1'b1, 10'h0C0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
